l1_trig_fifo: RTL

- Trigger register stage directly downstream of the trigger expander.
- Each accepted L1 trigger pulse is timestamped with the bunch-crossing ID it refers to (current BCID minus latency) and a running L1 ID, then queued for the readout controller.
- Drives the L1_Reg_Full backpressure flag consumed by the trigger expander.
- Readout side uses a valid/ack handshake.

---
 rtl/l1_trig_fifo.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/l1_trig_fifo.sv
// l1_trig_fifo: L1 trigger register stage downstream of the trigger expander.
// Each accepted trigger is stamped with (BCID - Latency) and a running L1 ID,
// then queued for the readout controller (valid/ack handshake).
// Optional build macro TMR_EN: triplicates all control state (BCID/L1ID
// counters, pointers, count, drop counter) with 2-of-3 voting and scrubbing.
// The storage array is intentionally not reset; only pointers qualify it.
module l1_trig_fifo #(
  parameter int DEPTH  = 16,
  parameter int BCID_W = 8,
  parameter int L1ID_W = 5,
  parameter int DROP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Trig_In,
  input  logic [BCID_W-1:0] Latency,
  input  logic              Bcr,
  input  logic              Ecr,
  output logic              L1_Reg_Full,
  output logic              Trig_Valid,
  output logic [BCID_W-1:0] Trig_Bcid,
  output logic [L1ID_W-1:0] Trig_L1id,
  input  logic              Trig_Ack,
  output logic [DROP_W-1:0] Drop_Cnt,
  output logic              Empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = BCID_W + L1ID_W;
  localparam int ST_W  = BCID_W + L1ID_W + 2 * PTR_W + CNT_W + DROP_W;

  localparam logic [BCID_W-1:0] BCID_ONE  = BCID_W'(1);
  localparam logic [L1ID_W-1:0] L1ID_ONE  = L1ID_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_ONE  = DROP_W'(1);
  localparam logic [DROP_W-1:0] DROP_SAT  = {DROP_W{1'b1}};

  // Current (voted, in TMR builds) control state, unpacked
  logic [ST_W-1:0]   st_v_s;
  logic [BCID_W-1:0] bcid_s;
  logic [L1ID_W-1:0] l1id_s;
  logic [PTR_W-1:0]  wptr_s;
  logic [PTR_W-1:0]  rptr_s;
  logic [CNT_W-1:0]  cnt_s;
  logic [DROP_W-1:0] dropcnt_s;

  // Next-state fields and packed next state
  logic [BCID_W-1:0] bcid_d;
  logic [L1ID_W-1:0] l1id_d;
  logic [PTR_W-1:0]  wptr_d;
  logic [PTR_W-1:0]  rptr_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [DROP_W-1:0] dropcnt_d;
  logic [ST_W-1:0]   st_d;

  // Event decode
  logic              full_s;
  logic              empty_s;
  logic              wr_s;
  logic              drop_evt_s;
  logic              pop_s;
  logic [BCID_W-1:0] ts_s;
  logic [ENT_W-1:0]  head_s;

  logic [ENT_W-1:0]  mem_q [DEPTH];

`ifdef TMR_EN
  logic [ST_W-1:0] st_q [3];

  function automatic logic [ST_W-1:0] maj3(input logic [ST_W-1:0] a,
                                            input logic [ST_W-1:0] b,
                                            input logic [ST_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign st_v_s = maj3(st_q[0], st_q[1], st_q[2]);

  // Triplicated state: every copy reloads from the voted next state (scrub)
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 3; i++) begin
        st_q[i] <= {ST_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        st_q[i] <= st_d;
      end
    end
  end
`else
  logic [ST_W-1:0] st_q;

  assign st_v_s = st_q;

  // Single-copy control state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      st_q <= {ST_W{1'b0}};
    end else begin
      st_q <= st_d;
    end
  end
`endif

  assign {bcid_s, l1id_s, wptr_s, rptr_s, cnt_s, dropcnt_s} = st_v_s;
  assign st_d = {bcid_d, l1id_d, wptr_d, rptr_d, cnt_d, dropcnt_d};

  // Fullness/emptiness come from the registered (pre-edge) count only
  assign full_s     = (cnt_s == CNT_FULL);
  assign empty_s    = (cnt_s == CNT_ZERO);
  assign wr_s       = Trig_In & ~Ecr & ~full_s;
  assign drop_evt_s = Trig_In & ~Ecr & full_s;
  assign pop_s      = Trig_Ack & ~Ecr & ~empty_s;
  assign ts_s       = bcid_s - Latency;

  // Next-state logic for counters, pointers, occupancy and drop counter
  always_comb begin
    bcid_d    = bcid_s;
    l1id_d    = l1id_s;
    wptr_d    = wptr_s;
    rptr_d    = rptr_s;
    cnt_d     = cnt_s;
    dropcnt_d = dropcnt_s;

    if (Bcr) begin
      bcid_d = {BCID_W{1'b0}};
    end else begin
      bcid_d = bcid_s + BCID_ONE;
    end

    if (Ecr) begin
      l1id_d    = {L1ID_W{1'b0}};
      wptr_d    = {PTR_W{1'b0}};
      rptr_d    = {PTR_W{1'b0}};
      cnt_d     = CNT_ZERO;
      dropcnt_d = {DROP_W{1'b0}};
    end else begin
      if (wr_s) begin
        wptr_d = wptr_s + PTR_ONE;
        l1id_d = l1id_s + L1ID_ONE;
      end else begin
        wptr_d = wptr_s;
        l1id_d = l1id_s;
      end

      if (pop_s) begin
        rptr_d = rptr_s + PTR_ONE;
      end else begin
        rptr_d = rptr_s;
      end

      if (wr_s && !pop_s) begin
        cnt_d = cnt_s + CNT_ONE;
      end else if (!wr_s && pop_s) begin
        cnt_d = cnt_s - CNT_ONE;
      end else begin
        cnt_d = cnt_s;
      end

      if (drop_evt_s && (dropcnt_s != DROP_SAT)) begin
        dropcnt_d = dropcnt_s + DROP_ONE;
      end else begin
        dropcnt_d = dropcnt_s;
      end
    end
  end

  // Entry storage: written on accepted triggers, never reset
  always_ff @(posedge Clk) begin
    if (wr_s) begin
      mem_q[wptr_s] <= {ts_s, l1id_s};
    end
  end

  // Head entry is masked to zero while nothing valid is queued
  assign head_s      = empty_s ? {ENT_W{1'b0}} : mem_q[rptr_s];
  assign Trig_Bcid   = head_s[ENT_W-1:L1ID_W];
  assign Trig_L1id   = head_s[L1ID_W-1:0];
  assign Trig_Valid  = ~empty_s;
  assign Empty       = empty_s;
  assign L1_Reg_Full = full_s;
  assign Drop_Cnt    = dropcnt_s;

endmodule
